// File: rtl/weight_stream_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : weight_stream_loader
// Description : Transmit side of the serial weight-load interface. Reads SIZE
//               signed BW-bit weights from a synchronous ROM (1-cycle read
//               latency) and streams them one per cycle on o_data/o_ce into
//               the conv/fc weight buffer. It then sends one zero flush beat
//               and waits for the buffer's full flag, or times out.
// Ports       : clk          - clock, rising edge
//               global_rst_n - asynchronous active-low reset
//               i_start      - start pulse (accepted in IDLE/DONE/ERR)
//               i_pause      - suppresses new ROM reads while high
//               o_rom_addr   - ROM read address (holds when o_rom_en=0)
//               o_rom_en     - ROM read enable
//               i_rom_data   - ROM read data, valid one cycle after o_rom_en
//               o_data       - weight byte to the buffer
//               o_ce         - write strobe to the buffer
//               i_buf_full   - buffer full flag
//               o_busy       - high in STREAM, FLUSH and WAIT_FULL
//               o_done       - level, high in DONE
//               o_err        - level, high in ERR (full flag timed out)
// Revision    : 1.0 - initial release
// ============================================================================
module weight_stream_loader #(
  parameter int BW      = 8,
  parameter int SIZE    = 3220,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_en,
  input  logic [BW-1:0]     i_rom_data,
  output logic [BW-1:0]     o_data,
  output logic              o_ce,
  input  logic              i_buf_full,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = $clog2(SIZE + 2);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SIZE - 1);
  localparam logic [CNT_W-1:0]  TOTAL_BEATS = CNT_W'(SIZE + 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT   = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STREAM    = 3'd1,
    S_FLUSH     = 3'd2,
    S_WAIT_FULL = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [TMR_W-1:0]  timer;

  // Beat pipeline. The enable register marks a read in flight; the ROM word
  // appears on i_rom_data one cycle later, when rd_valid is high, and is
  // captured into o_data together with o_ce. The flush token walks the same
  // two stages so the zero beat lands directly behind the last weight.
  logic              rd_valid;
  logic              flush_0;
  logic              flush_1;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      beat_cnt   <= '0;
      timer      <= '0;
      rd_valid   <= 1'b0;
      flush_0    <= 1'b0;
      flush_1    <= 1'b0;
      o_rom_addr <= '0;
      o_rom_en   <= 1'b0;
      o_data     <= '0;
      o_ce       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      // Pipeline advances every cycle regardless of state or pause, so a
      // read issued just before pause rises is still delivered.
      rd_valid <= o_rom_en;
      flush_0  <= 1'b0;
      flush_1  <= flush_0;
      o_ce     <= rd_valid | flush_1;
      o_data   <= flush_1 ? '0 : i_rom_data;
      if (rd_valid | flush_1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      o_rom_en <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            state    <= S_STREAM;
            addr     <= '0;
            beat_cnt <= '0;
            timer    <= '0;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
          end
        end

        S_STREAM: begin
          if (!i_pause) begin
            o_rom_en   <= 1'b1;
            o_rom_addr <= addr;
            addr       <= addr + 1'b1;
            if (addr == LAST_ADDR) begin
              state <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          flush_0 <= 1'b1;
          state   <= S_WAIT_FULL;
        end

        S_WAIT_FULL: begin
          // The full flag and the timer only matter once the flush beat has
          // actually left, i.e. all SIZE+1 beats have been strobed.
          if (beat_cnt == TOTAL_BEATS) begin
            if (i_buf_full) begin
              state  <= S_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else if ((timer + 1'b1) == TMR_LIMIT) begin
              timer  <= timer + 1'b1;
              state  <= S_ERR;
              o_busy <= 1'b0;
              o_err  <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          o_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_weight_stream_loader
// Description : Self-checking bench for weight_stream_loader. A ROM model and
//               a buffer model surround the DUT; a negedge monitor records
//               beats, reads and status edges, and directed steps compare them
//               with sequences built from the ROM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_stream_loader;

  localparam int BW      = 8;
  localparam int SIZE    = 5;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [BW-1:0]     rom_q;
  logic [BW-1:0]     data;
  logic              ce;
  logic              buf_full;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  weight_stream_loader #(
    .BW(BW), .SIZE(SIZE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .global_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .o_rom_addr(rom_addr), .o_rom_en(rom_en), .i_rom_data(rom_q),
    .o_data(data), .o_ce(ce), .i_buf_full(buf_full),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Synchronous ROM, one-cycle latency
  logic signed [BW-1:0] rom [SIZE];
  always @(posedge clk) begin
    if (rom_en) rom_q <= rom[int'(rom_addr)];
  end

  // Buffer model: counts strobes and raises full once SIZE+1 beats arrived
  logic never_full;
  logic buf_clr;
  int   bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt     <= 0;
      buf_full <= 1'b0;
    end else if (buf_clr) begin
      bcnt     <= 0;
      buf_full <= 1'b0;
    end else begin
      if (ce) bcnt <= bcnt + 1;
      buf_full <= !never_full && ((bcnt + int'(ce)) >= SIZE + 1);
    end
  end

  // Monitor (only writer of the recorded data)
  logic                 mon_clr;
  int                   cyc = 0;
  int                   beat_cyc [$];
  logic signed [BW-1:0] beat_dat [$];
  int                   rd_addr  [$];
  int                   done_rises = 0;
  int                   err_cyc = -1;
  logic                 prev_done = 1'b0;
  logic                 prev_err = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      beat_cyc.delete();
      beat_dat.delete();
      rd_addr.delete();
      done_rises = 0;
      err_cyc    = -1;
    end
    if (ce === 1'b1) begin
      beat_cyc.push_back(cyc);
      beat_dat.push_back(data);
    end
    if (rom_en === 1'b1) rd_addr.push_back(int'(rom_addr));
    if (done === 1'b1 && prev_done !== 1'b1) done_rises = done_rises + 1;
    if (err === 1'b1 && prev_err !== 1'b1 && err_cyc < 0) err_cyc = cyc;
    prev_done = done;
    prev_err  = err;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic with_pause);
    start   = 1'b1;
    buf_clr = 1'b1;
    pause   = with_pause;
    mon_clr = 1'b1;
    tick();
    start   = 1'b0;
    buf_clr = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_end(input string tag, input logic rnd_pause);
    int n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 100) begin
      if (rnd_pause) pause = ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    pause = 1'b0;
    check({tag, "_finished"}, done | err, 1);
  endtask

  // Expected stream: every ROM word in address order, then one zero beat.
  // gap_idx >= 0 expects gap_len idle cycles after beat gap_idx and none
  // elsewhere; gap_idx < 0 skips the spacing check.
  task automatic check_stream(input string tag, input int gap_idx, input int gap_len);
    logic signed [31:0] exp;
    check({tag, "_nbeats"}, beat_dat.size(), SIZE + 1);
    check({tag, "_nreads"}, rd_addr.size(), SIZE);
    for (int i = 0; i < SIZE + 1 && i < beat_dat.size(); i++) begin
      exp = (i < SIZE) ? rom[i] : 0;
      check($sformatf("%s_beat%0d", tag, i), beat_dat[i], exp);
    end
    for (int i = 0; i < rd_addr.size() && i < SIZE; i++)
      check($sformatf("%s_addr%0d", tag, i), rd_addr[i], i);
    if (gap_idx >= 0) begin
      for (int i = 1; i < beat_cyc.size(); i++)
        check($sformatf("%s_gap%0d", tag, i - 1), beat_cyc[i] - beat_cyc[i-1] - 1,
              (i - 1 == gap_idx) ? gap_len : 0);
    end
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done_rises"}, done_rises, 1);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    never_full = 1'b0; buf_clr = 1'b0; mon_clr = 1'b0;
    rom[0] = 8'sd1; rom[1] = -8'sd2; rom[2] = 8'sd3; rom[3] = -8'sd4; rom[4] = 8'sd5;
    repeat (3) tick();
    check("reset_outs", {rom_addr, rom_en, data, ce, busy, done, err}, 0);
    rst_n = 1'b1;
    tick();

    // T1: plain run, six back-to-back beats
    start_run(1'b0);
    check("t1_busy", busy, 1);
    wait_end("t1", 1'b0);
    check_stream("t1", 0, 0);
    check_done("t1");

    // T2: pause for 3 cycles right after the second read
    start_run(1'b0);
    n = 0;
    while (rd_addr.size() < 2 && n < 20) begin tick(); n++; end
    check("t2_second_read", rd_addr.size(), 2);
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    wait_end("t2", 1'b0);
    check_stream("t2", 1, 3);
    check_done("t2");

    // T3: buffer never full -> error TIMEOUT cycles after the flush beat
    never_full = 1'b1;
    start_run(1'b0);
    wait_end("t3", 1'b0);
    check_stream("t3", 0, 0);
    check("t3_err", err, 1);
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    if (beat_cyc.size() > 0)
      check("t3_err_delay", err_cyc - beat_cyc[beat_cyc.size()-1], TIMEOUT);
    repeat (3) tick();
    check("t3_err_hold", err, 1);
    never_full = 1'b0;

    // T4: start from ERR, then a stray start while streaming is ignored
    start_run(1'b0);
    check("t4_err_cleared", err, 0);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end("t4a", 1'b0);
    check_stream("t4a", 0, 0);
    check_done("t4a");
    start_run(1'b0);
    check("t4_done_cleared", done, 0);
    wait_end("t4b", 1'b0);
    check_stream("t4b", 0, 0);
    check_done("t4b");

    // T5: asynchronous reset after the third beat
    start_run(1'b0);
    n = 0;
    while (beat_dat.size() < 3 && n < 20) begin tick(); n++; end
    check("t5_three_beats", beat_dat.size(), 3);
    rst_n = 1'b0;
    #1;
    check("t5_async_outs", {rom_addr, rom_en, data, ce, busy, done, err}, 0);
    check("t5_buf_cleared", {buf_full, bcnt != 0}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_run(1'b0);
    wait_end("t5", 1'b0);
    check_stream("t5", 0, 0);
    check_done("t5");

    // T6: start with pause held, no reads until pause drops
    start_run(1'b1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t6_busy%0d", k), busy, 1);
      check($sformatf("t6_noread%0d", k), rom_en, 0);
      if (k < 4) tick();
    end
    pause = 1'b0;
    wait_end("t6", 1'b0);
    check_stream("t6", 0, 0);
    check_done("t6");

    // Random ROM contents with random pause patterns
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < SIZE; i++) rom[i] = BW'($urandom);
      start_run(1'b0);
      wait_end($sformatf("rnd%0d", r), 1'b1);
      check_stream($sformatf("rnd%0d", r), -1, 0);
      check_done($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
